// File: rtl/vga_computer_irq_pkg.sv
// Shared constants for the VGA computer interrupt controller: register map,
// bit positions and the source-count limit.
package vga_computer_irq_pkg;

   localparam int MAX_IRQ      = 16;
   localparam int CTRL_EN_BIT  = 0;
   localparam int ID_VALID_BIT = 15;

   typedef enum logic [2:0] {
      ADDR_PENDING = 3'd0,
      ADDR_MASK    = 3'd1,
      ADDR_ACTIVE  = 3'd2,
      ADDR_ID      = 3'd3,
      ADDR_SWSET   = 3'd4,
      ADDR_CTRL    = 3'd5
   } reg_addr_e;

   // Ones in the bit positions that correspond to implemented sources.
   function automatic logic [MAX_IRQ-1:0] src_mask(input int n);
      logic [MAX_IRQ-1:0] m;
      for (int i = 0; i < MAX_IRQ; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/vga_computer_irq_if.sv
// Avalon-MM slave bus used by the interrupt controller (same shape as the
// interval timer: 16-bit data, 3-bit word address, registered readdata).
interface vga_computer_irq_if;
   logic        chipselect;
   logic        write_n;
   logic [2:0]  address;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output chipselect, write_n, address, writedata,
      input  readdata
   );

   modport slave (
      input  chipselect, write_n, address, writedata,
      output readdata
   );
endinterface

// File: rtl/vga_computer_irq_prio_enc.sv
// Lowest-index-first priority encoder over the full 16-bit source vector.
module vga_computer_irq_prio_enc
   import vga_computer_irq_pkg::*;
(
   input  logic [MAX_IRQ-1:0] vec_i,
   output logic [3:0]         idx_o,
   output logic               valid_o
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx_o   = 4'd0;
      valid_o = |vec_i;
      for (int i = MAX_IRQ - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = i[3:0];
         end
      end
   end

endmodule

// File: rtl/vga_computer_irq_ctrl.sv
// Interrupt controller: per-source edge/level capture, mask, global enable,
// registered CPU irq and a lowest-index-first ID register.
module vga_computer_irq_ctrl
   import vga_computer_irq_pkg::*;
#(
   parameter int                 NUM_IRQ   = 8,
   parameter logic [MAX_IRQ-1:0] EDGE_MASK = 16'h0000
)(
   input  logic               clk,
   input  logic               reset_n,
   vga_computer_irq_if.slave  bus,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq
);

   localparam logic [MAX_IRQ-1:0] SRC_MASK = src_mask(NUM_IRQ);

   logic               wr_en;
   logic               wr_pending, wr_mask, wr_swset, wr_ctrl;
   logic [MAX_IRQ-1:0] pending_q, pending_d;
   logic [MAX_IRQ-1:0] mask_q, mask_d;
   logic [MAX_IRQ-1:0] active;
   logic               ctrl_en_q, ctrl_en_d;
   logic               irq_q, irq_d;
   logic [15:0]        rdata_q, rdata_d;
   logic [3:0]         id_idx;
   logic               id_valid;

   assign wr_en      = bus.chipselect & ~bus.write_n;
   assign wr_pending = wr_en & (bus.address == ADDR_PENDING);
   assign wr_mask    = wr_en & (bus.address == ADDR_MASK);
   assign wr_swset   = wr_en & (bus.address == ADDR_SWSET);
   assign wr_ctrl    = wr_en & (bus.address == ADDR_CTRL);

   for (genvar gi = 0; gi < MAX_IRQ; gi++) begin : g_bit
      if (gi < NUM_IRQ) begin : g_src
         if (EDGE_MASK[gi]) begin : g_edge
            // Only edge sources need input history; level sources just follow irq_in.
            logic in_prev_q;
            logic set_ev, clr_ev;

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  in_prev_q <= 1'b0;
               end else begin
                  in_prev_q <= irq_in[gi];
               end
            end

            assign set_ev = (irq_in[gi] & ~in_prev_q) | (wr_swset & bus.writedata[gi]);
            assign clr_ev = wr_pending & bus.writedata[gi];
            // A new event beats a simultaneous W1C so nothing is lost.
            assign pending_d[gi] = set_ev | (pending_q[gi] & ~clr_ev);
         end else begin : g_level
            assign pending_d[gi] = irq_in[gi];
         end
      end else begin : g_absent
         assign pending_d[gi] = 1'b0;
      end
   end

   assign mask_d    = wr_mask ? (bus.writedata & SRC_MASK) : mask_q;
   assign ctrl_en_d = wr_ctrl ? bus.writedata[CTRL_EN_BIT] : ctrl_en_q;
   assign active    = pending_q & mask_q;
   assign irq_d     = ctrl_en_q & (|active);

   vga_computer_irq_prio_enc u_prio_enc (
      .vec_i   (active),
      .idx_o   (id_idx),
      .valid_o (id_valid)
   );

   // Read mux sees pre-write register state; readdata updates every cycle.
   always_comb begin
      rdata_d = '0;
      case (bus.address)
         ADDR_PENDING: rdata_d = pending_q;
         ADDR_MASK:    rdata_d = mask_q;
         ADDR_ACTIVE:  rdata_d = active;
         ADDR_ID: begin
            rdata_d[ID_VALID_BIT] = id_valid;
            rdata_d[3:0]          = id_idx;
         end
         ADDR_CTRL:    rdata_d[CTRL_EN_BIT] = ctrl_en_q;
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= '0;
         mask_q    <= '0;
         ctrl_en_q <= 1'b0;
         irq_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         ctrl_en_q <= ctrl_en_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_vga_computer_irq_ctrl.sv
// Scoreboard bench for vga_computer_irq_ctrl: directed scenarios then random
// traffic, all checked against a register-level model of the controller.
module tb_vga_computer_irq_ctrl;

   localparam int          N  = 8;
   localparam logic [15:0] EM = 16'h0011;

   typedef struct {
      logic        irq;
      logic [15:0] rd;
      bit          chk_rd_lit;
      logic [15:0] rd_lit;
      bit          chk_irq_lit;
      logic        irq_lit;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] irq_in;
   logic [N-1:0] irq_nxt;
   logic         irq;

   int checks   = 0;
   int failures = 0;

   exp_t exp_q[$];

   // Reference model state.
   logic [15:0]  m_pend;
   logic [15:0]  m_mask;
   bit           m_en;
   logic [N-1:0] m_prev;

   vga_computer_irq_if bus_if ();

   vga_computer_irq_ctrl #(
      .NUM_IRQ   (N),
      .EDGE_MASK (EM)
   ) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus_if),
      .irq_in  (irq_in),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void m_reset();
      m_pend = '0;
      m_mask = '0;
      m_en   = 1'b0;
      m_prev = '0;
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a);
      logic [15:0] act;
      logic [15:0] r;
      bit          found;
      act   = m_pend & m_mask;
      r     = '0;
      found = 1'b0;
      case (a)
         3'd0: r = m_pend;
         3'd1: r = m_mask;
         3'd2: r = act;
         3'd3: begin
            for (int i = 0; i < 16; i++) begin
               if (act[i] && !found) begin
                  r     = 16'h8000 | 16'(i);
                  found = 1'b1;
               end
            end
         end
         3'd5: r = {15'd0, m_en};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic void m_step(input bit cs, input bit wn, input logic [2:0] a,
                                  input logic [15:0] wd, input logic [N-1:0] iv);
      bit          w;
      logic [15:0] np;
      bit          rose, sw, clr;
      w  = cs && !wn;
      np = '0;
      for (int i = 0; i < N; i++) begin
         if (EM[i]) begin
            rose  = iv[i] && !m_prev[i];
            sw    = w && (a == 3'd4) && wd[i];
            clr   = w && (a == 3'd0) && wd[i];
            np[i] = rose || sw || (m_pend[i] && !clr);
         end else begin
            np[i] = iv[i];
         end
      end
      m_pend = np;
      if (w && a == 3'd1) begin
         m_mask = '0;
         for (int i = 0; i < N; i++) m_mask[i] = wd[i];
      end
      if (w && a == 3'd5) m_en = wd[0];
      m_prev = iv;
   endfunction

   task automatic cyc(input bit cs, input bit wn, input logic [2:0] a, input logic [15:0] wd,
                      input bit crd, input logic [15:0] lrd, input bit cirq, input bit lirq);
      exp_t e;
      @(negedge clk);
      bus_if.chipselect = cs;
      bus_if.write_n    = wn;
      bus_if.address    = a;
      bus_if.writedata  = wd;
      irq_in            = irq_nxt;
      e.irq         = m_en && ((m_pend & m_mask) != 16'd0);
      e.rd          = m_read(a);
      e.chk_rd_lit  = crd;
      e.rd_lit      = lrd;
      e.chk_irq_lit = cirq;
      e.irq_lit     = lirq;
      exp_q.push_back(e);
      m_step(cs, wn, a, wd, irq_nxt);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cyc(1'b1, 1'b0, a, d, 1'b0, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b1, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic rdx(input logic [2:0] a, input bit crd, input logic [15:0] lrd,
                      input bit cirq, input bit lirq);
      cyc(1'b1, 1'b1, a, 16'd0, crd, lrd, cirq, lirq);
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      irq_in            = '0;
      irq_nxt           = '0;
      #1;
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL %s_irq: got %b expected 0", tag, irq);
      end
      checks++;
      if (bus_if.readdata !== 16'd0) begin
         failures++;
         $display("FAIL %s_readdata: got %h expected 0000", tag, bus_if.readdata);
      end
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: one expected record per clock edge, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (irq !== e.irq) begin
               failures++;
               $display("FAIL irq_model t=%0t: got %b expected %b", $time, irq, e.irq);
            end
            checks++;
            if (bus_if.readdata !== e.rd) begin
               failures++;
               $display("FAIL readdata_model t=%0t: got %h expected %h", $time, bus_if.readdata, e.rd);
            end
            if (e.chk_rd_lit) begin
               checks++;
               if (bus_if.readdata !== e.rd_lit) begin
                  failures++;
                  $display("FAIL readdata_plan t=%0t: got %h expected %h", $time, bus_if.readdata, e.rd_lit);
               end
            end
            if (e.chk_irq_lit) begin
               checks++;
               if (irq !== e.irq_lit) begin
                  failures++;
                  $display("FAIL irq_plan t=%0t: got %b expected %b", $time, irq, e.irq_lit);
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] r;
      bit          cs, wn;
      logic [2:0]  a;
      logic [15:0] wd;

      rst_n             = 1'b1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.address    = 3'd0;
      bus_if.writedata  = 16'd0;
      irq_in            = '0;
      irq_nxt           = '0;
      m_reset();
      #2 rst_n = 1'b0;
      #20;
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state: every address reads 0, irq low.
      for (int i = 0; i < 8; i++) rdx(3'(i), 1'b1, 16'h0000, 1'b1, 1'b0);

      // Timer tick on edge source 0, then W1C.
      wr(3'd1, 16'h0001);
      wr(3'd5, 16'h0001);
      irq_nxt = 8'h01; idle();
      irq_nxt = 8'h00; rdx(3'd0, 1'b1, 16'h0001, 1'b1, 1'b1);
      rdx(3'd0, 1'b1, 16'h0001, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 3'd0, 16'h0001, 1'b0, 16'd0, 1'b1, 1'b1);
      rdx(3'd3, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Level source 3 held for 5 cycles; W1C has no effect on it.
      wr(3'd1, 16'h0008);
      irq_nxt = 8'h08; idle();
      rdx(3'd0, 1'b0, 16'd0, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 3'd0, 16'h0008, 1'b0, 16'd0, 1'b1, 1'b1);
      rdx(3'd0, 1'b1, 16'h0008, 1'b1, 1'b1);
      rdx(3'd0, 1'b0, 16'd0, 1'b1, 1'b1);
      irq_nxt = 8'h00; rdx(3'd0, 1'b0, 16'd0, 1'b1, 1'b1);
      rdx(3'd0, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Edge source 0: W1C coincident with a new rising edge keeps pending.
      wr(3'd1, 16'h0001);
      irq_nxt = 8'h01; idle();
      irq_nxt = 8'h00; idle();
      irq_nxt = 8'h01; cyc(1'b1, 1'b0, 3'd0, 16'h0001, 1'b0, 16'd0, 1'b1, 1'b1);
      rdx(3'd0, 1'b1, 16'h0001, 1'b1, 1'b1);
      rdx(3'd2, 1'b1, 16'h0001, 1'b1, 1'b1);
      irq_nxt = 8'h00; wr(3'd0, 16'h0001);

      // ID priority and global enable gating.
      irq_nxt = 8'h24; wr(3'd1, 16'h0024);
      rdx(3'd3, 1'b1, 16'h8002, 1'b1, 1'b1);
      wr(3'd1, 16'h0020);
      rdx(3'd3, 1'b1, 16'h8005, 1'b1, 1'b1);
      wr(3'd5, 16'h0000);
      rdx(3'd2, 1'b1, 16'h0020, 1'b1, 1'b0);

      // Software set while masked, then enable; async reset mid-sequence.
      irq_nxt = 8'h00; wr(3'd1, 16'h0000);
      idle();
      wr(3'd4, 16'h0001);
      rdx(3'd0, 1'b1, 16'h0001, 1'b1, 1'b0);
      wr(3'd1, 16'h0001);
      wr(3'd5, 16'h0001);
      rdx(3'd2, 1'b1, 16'h0001, 1'b1, 1'b1);
      async_reset("midseq_reset");
      for (int i = 0; i < 8; i++) rdx(3'(i), 1'b1, 16'h0000, 1'b1, 1'b0);

      // Random traffic.
      for (int k = 0; k < 1500; k++) begin
         if (k == 750) async_reset("random_reset");
         r       = $urandom & $urandom;
         irq_nxt = irq_nxt ^ r[N-1:0];
         cs      = ($urandom_range(0, 3) != 0);
         wn      = ($urandom_range(0, 2) != 0);
         a       = 3'($urandom_range(0, 7));
         wd      = 16'($urandom);
         cyc(cs, wn, a, wd, 1'b0, 16'd0, 1'b0, 1'b0);
      end

      idle();
      @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
